// File: rtl/spi_frame_master.sv
// spi_frame_master
//   SPI initiator issuing 16-bit register frames {rw, addr[6:0], data[7:0]},
//   MSB first, to the calculator's SPI slave. SCLK idles low; MOSI changes on
//   SCLK rise, MISO is captured on the clk edge that drives SCLK low.
//
// Ports
//   clk, rst         system clock, asynchronous active-high reset
//   start            one-cycle frame request, sampled only while busy=0
//   rw, addr, wdata  frame type (1=read), register address, write data
//   busy, done       frame in progress / one-cycle end-of-frame pulse
//   rdata            read result, valid from done, held until next read
//   sclk, cs_n, mosi, miso   SPI pins
module spi_frame_master #(
    parameter int unsigned HALF_DIV = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(HALF_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HI,
        S_LO,
        S_TRAIL,
        S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     bit_q, bit_d;
    logic [15:0]    shift_q, shift_d;
    logic           rw_q, rw_d;
    logic           sclk_q, sclk_d;
    logic           cs_n_q, cs_n_d;
    logic           mosi_q, mosi_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [7:0]     rdata_q, rdata_d;
    logic           tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rw_q    <= 1'b0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rw_q    <= rw_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? RELOAD : cnt_q - CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        rw_d    = rw_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_LEAD;
                    cnt_d   = RELOAD;
                    bit_d   = '0;
                    rw_d    = rw;
                    shift_d = {rw, addr, rw ? 8'h00 : wdata};
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_LEAD: begin
                if (tick) begin
                    state_d = S_HI;
                    sclk_d  = 1'b1;
                    mosi_d  = shift_q[15];
                    shift_d = {shift_q[14:0], 1'b0};
                end
            end
            S_HI: begin
                if (tick) begin
                    sclk_d = 1'b0;
                    if (rw_q && bit_q[3]) begin
                        rdata_d = {rdata_q[6:0], miso};
                    end
                    // The low half of bit 15 is spent in TRAIL, so cs_n rises
                    // one half-period after the last SCLK fall.
                    state_d = (bit_q == 4'd15) ? S_TRAIL : S_LO;
                end
            end
            S_LO: begin
                if (tick) begin
                    state_d = S_HI;
                    sclk_d  = 1'b1;
                    bit_d   = bit_q + 4'd1;
                    mosi_d  = shift_q[15];
                    shift_d = {shift_q[14:0], 1'b0};
                end
            end
            S_TRAIL: begin
                if (tick) begin
                    state_d = S_GAP;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                end
            end
            S_GAP: begin
                if (tick) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    bit_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign sclk  = sclk_q;
    assign cs_n  = cs_n_q;
    assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_frame_master.sv
module tb_spi_frame_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [2:0] start_w, miso_w, busy_w, done_w, sclk_w, cs_n_w, mosi_w;
    logic [7:0] rdata_w [3];

    int unsigned hdiv [3] = '{4, 2, 50};
    logic [7:0]  last_rd [3];
    int n_checks = 0;
    int n_errors = 0;

    spi_frame_master #(.HALF_DIV(4)) u_h4 (
        .clk(clk), .rst(rst), .start(start_w[0]), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_w[0]), .done(done_w[0]), .rdata(rdata_w[0]), .sclk(sclk_w[0]),
        .cs_n(cs_n_w[0]), .mosi(mosi_w[0]), .miso(miso_w[0]));

    spi_frame_master #(.HALF_DIV(2)) u_h2 (
        .clk(clk), .rst(rst), .start(start_w[1]), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_w[1]), .done(done_w[1]), .rdata(rdata_w[1]), .sclk(sclk_w[1]),
        .cs_n(cs_n_w[1]), .mosi(mosi_w[1]), .miso(miso_w[1]));

    spi_frame_master #(.HALF_DIV(50)) u_h50 (
        .clk(clk), .rst(rst), .start(start_w[2]), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_w[2]), .done(done_w[2]), .rdata(rdata_w[2]), .sclk(sclk_w[2]),
        .cs_n(cs_n_w[2]), .mosi(mosi_w[2]), .miso(miso_w[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input int idx, input string tag);
        check({tag, "_cs_n"},  32'(cs_n_w[idx]),  32'd1);
        check({tag, "_sclk"},  32'(sclk_w[idx]),  32'd0);
        check({tag, "_mosi"},  32'(mosi_w[idx]),  32'd0);
        check({tag, "_busy"},  32'(busy_w[idx]),  32'd0);
        check({tag, "_rdata"}, 32'(rdata_w[idx]), 32'(last_rd[idx]));
    endtask

    // One frame observed from the pin level. The slave model presents resp on
    // bits 8..15 of a read, MSB first, changing MISO right after each SCLK rise.
    // Timing is measured in clk edges t after the edge that accepts start.
    task automatic run_frame(input int idx, input logic f_rw, input logic [6:0] f_addr,
                             input logic [7:0] f_wd, input logic [7:0] resp,
                             input bit chained, input bit chain_next,
                             input int stray0, input int stray1, input int abort_at);
        int h, t_end, nrise, nfall, bad_edge, cs_low, cs_tog, ndone, done_t;
        logic [15:0] dec, exp_frame;
        logic prev_s, prev_cs, s, busy_at_done, mosi_after;
        logic [7:0] rd_at_done;
        h = int'(hdiv[idx]);
        t_end = 34 * h;
        nrise = 0; nfall = 0; bad_edge = 0; cs_low = 0; cs_tog = 0; ndone = 0; done_t = -1;
        dec = '0; busy_at_done = 1'b1; mosi_after = 1'b1; rd_at_done = '0;
        rw = f_rw; addr = f_addr; wdata = f_wd;
        if (!chained) start_w[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_w[idx] = 1'b0;
        miso_w[idx] = 1'b0;
        prev_s = 1'b0;
        prev_cs = 1'b1;
        check("start_cs_n", 32'(cs_n_w[idx]), 32'd0);
        check("start_busy", 32'(busy_w[idx]), 32'd1);
        for (int t = 0; t <= t_end; t++) begin
            if (t > 0) @(negedge clk);
            start_w[idx] = (t == stray0 || t == stray1);
            if (t == abort_at) begin
                #1 rst = 1'b1;
                #1;
                for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;
                check_idle(idx, "abort");
                ndone = 0;
                repeat (3) begin
                    @(negedge clk);
                    if (done_w[idx] !== 1'b0) ndone++;
                end
                rst = 1'b0;
                start_w[idx] = 1'b0;
                repeat (3 * h) begin
                    @(negedge clk);
                    if (done_w[idx] !== 1'b0 || cs_n_w[idx] !== 1'b1) ndone++;
                end
                check("abort_no_done", 32'(ndone), 32'd0);
                return;
            end
            s = sclk_w[idx];
            if (s && !prev_s) begin
                if (t != h + 2 * h * nrise) bad_edge++;
                miso_w[idx] = (f_rw && nrise >= 8 && nrise < 16) ? resp[15 - nrise] : 1'b0;
                nrise++;
            end
            if (!s && prev_s) begin
                if (t != 2 * h + 2 * h * nfall) bad_edge++;
                dec = {dec[14:0], mosi_w[idx]};
                nfall++;
            end
            if (cs_n_w[idx] === 1'b0) cs_low++;
            if (cs_n_w[idx] !== prev_cs) cs_tog++;
            if (done_w[idx] !== 1'b0) begin
                ndone++;
                done_t = t;
                busy_at_done = busy_w[idx];
                rd_at_done = rdata_w[idx];
            end
            if (t == 33 * h) mosi_after = mosi_w[idx];
            prev_s = s;
            prev_cs = cs_n_w[idx];
        end
        if (chain_next) start_w[idx] = 1'b1;

        if (f_rw) last_rd[idx] = resp;
        exp_frame = {f_rw, f_addr, f_wd};
        if (f_rw) check("hdr_read", 32'(dec[15:8]), 32'(exp_frame[15:8]));
        else      check("frame_write", 32'(dec), 32'(exp_frame));
        check("sclk_rises", 32'(nrise), 32'd16);
        check("sclk_falls", 32'(nfall), 32'd16);
        check("edge_timing_bad", 32'(bad_edge), 32'd0);
        check("cs_low_cycles", 32'(cs_low), 32'(33 * h));
        check("cs_toggles", 32'(cs_tog), 32'd2);
        check("done_count", 32'(ndone), 32'd1);
        check("done_time", 32'(done_t), 32'(t_end));
        check("busy_at_done", 32'(busy_at_done), 32'd0);
        check("mosi_after_cs", 32'(mosi_after), 32'd0);
        check("rdata_at_done", 32'(rd_at_done), 32'(last_rd[idx]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       r_rw;
        logic [6:0] r_addr;
        logic [7:0] r_wd, r_resp;
        int         r_idx;
        rst = 1'b1;
        start_w = '0;
        miso_w = '0;
        rw = 1'b0;
        addr = '0;
        wdata = '0;
        for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_idle(i, "reset");
            check("reset_done", 32'(done_w[i]), 32'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // directed frames on H=4
        run_frame(0, 1'b0, 7'h01, 8'h3C, 8'h00, 0, 0, -1, -1, -1);
        repeat (2) @(negedge clk);
        run_frame(0, 1'b1, 7'h07, 8'h00, 8'hA5, 0, 0, -1, -1, -1);
        repeat (2) @(negedge clk);
        run_frame(0, 1'b1, 7'h12, 8'h00, 8'h5A, 0, 0, -1, -1, -1);
        run_frame(0, 1'b0, 7'h13, 8'hFF, 8'h00, 0, 0, -1, -1, -1);
        repeat (2) @(negedge clk);
        // stray starts mid-frame, then start on the done cycle
        run_frame(0, 1'b0, 7'h2A, 8'h81, 8'h00, 0, 1, 10, 60, -1);
        run_frame(0, 1'b1, 7'h55, 8'h00, 8'hC3, 1, 0, -1, -1, -1);
        repeat (2) @(negedge clk);
        // reset during bit 9 of a read, then a clean frame
        run_frame(0, 1'b1, 7'h07, 8'h00, 8'hA5, 0, 0, -1, -1, 19 * 4 + 1);
        run_frame(0, 1'b1, 7'h07, 8'h00, 8'h96, 0, 0, -1, -1, -1);

        // other divider settings
        run_frame(1, 1'b0, 7'h40, 8'h69, 8'h00, 0, 0, -1, -1, -1);
        run_frame(1, 1'b1, 7'h3F, 8'h00, 8'h1E, 0, 0, -1, -1, -1);
        run_frame(2, 1'b1, 7'h05, 8'h00, 8'hE7, 0, 0, -1, -1, -1);
        run_frame(2, 1'b0, 7'h06, 8'h42, 8'h00, 0, 0, -1, -1, -1);

        // randomized frames
        for (int n = 0; n < 30; n++) begin
            r_idx  = (n % 10 == 9) ? 2 : ((n % 3 == 0) ? 1 : 0);
            r_rw   = 1'($urandom);
            r_addr = 7'($urandom);
            r_wd   = 8'($urandom);
            r_resp = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frame(r_idx, r_rw, r_addr, r_wd, r_resp, 0, 0, -1, -1, -1);
        end

        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle(i, "final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
